// File: rtl/ber_win_cnt.sv
// Measurement-window BER counter: counts compared bits up to a programmed window
// length, counts mismatches in a saturating counter, latches the total at window end.
module ber_win_cnt #(
  parameter int BW_BIT = 16,
  parameter int BW_ERR = 16
) (
  input  logic              RSTX,
  input  logic              CLK,
  input  logic              START,
  input  logic              ABORT,
  input  logic [BW_BIT-1:0] WIN,
  input  logic              VLD,
  input  logic              ERR,
  output logic              BUSY,
  output logic              DONE,
  output logic [BW_BIT-1:0] BIT_CNT,
  output logic [BW_ERR-1:0] ERR_CNT,
  output logic              ERR_SAT
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BW_ERR-1:0] ERR_MAX = '1;

  state_t            state_q, state_d;
  logic [BW_BIT-1:0] win_q, win_d;
  logic [BW_BIT-1:0] bit_q, bit_d;
  logic [BW_BIT-1:0] bit_inc;
  logic [BW_ERR-1:0] err_q, err_d;
  logic [BW_ERR-1:0] err_nxt;
  logic              sat_q, sat_d;
  logic              sat_nxt;
  logic [BW_ERR-1:0] err_cnt_q, err_cnt_d;
  logic              err_sat_q, err_sat_d;
  logic              done_q, done_d;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    bit_d     = bit_q;
    err_d     = err_q;
    sat_d     = sat_q;
    err_cnt_d = err_cnt_q;
    err_sat_d = err_sat_q;
    done_d    = 1'b0;

    // bit_q stays below win_q while running, so this increment cannot wrap
    bit_inc = bit_q + BW_BIT'(1);
    err_nxt = err_q;
    sat_nxt = sat_q;
    if (ERR) begin
      if (err_q == ERR_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        err_nxt = err_q + BW_ERR'(1);
      end
    end

    if (ABORT) begin
      state_d = IDLE;
    end else if (START) begin
      state_d = RUN;
      win_d   = WIN;
      bit_d   = '0;
      err_d   = '0;
      sat_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (win_q == '0) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        err_cnt_d = '0;
        err_sat_d = 1'b0;
      end else if (VLD) begin
        bit_d = bit_inc;
        err_d = err_nxt;
        sat_d = sat_nxt;
        if (bit_inc == win_q) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          err_cnt_d = err_nxt;
          err_sat_d = sat_nxt;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q   <= IDLE;
      win_q     <= '0;
      bit_q     <= '0;
      err_q     <= '0;
      sat_q     <= 1'b0;
      err_cnt_q <= '0;
      err_sat_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      sat_q     <= sat_d;
      err_cnt_q <= err_cnt_d;
      err_sat_q <= err_sat_d;
      done_q    <= done_d;
    end
  end

  assign BUSY    = (state_q == RUN);
  assign DONE    = done_q;
  assign BIT_CNT = bit_q;
  assign ERR_CNT = err_cnt_q;
  assign ERR_SAT = err_sat_q;

endmodule

// File: tb/tb_ber_win_cnt.sv
// Bench for ber_win_cnt: hand-built vector table, saturation/reset sequences and
// random traffic, run on a 16-bit and a 4-bit error-counter instance side by side.
module tb_ber_win_cnt;

  logic        clk;
  logic        rstx;
  logic        start;
  logic        abort;
  logic [15:0] win;
  logic        vld;
  logic        err;

  logic        busy_a, done_a, sat_a;
  logic [15:0] bit_a, errc_a;
  logic        busy_b, done_b, sat_b;
  logic [15:0] bit_b;
  logic [3:0]  errc_b;

  int n_checks = 0;
  int n_errors = 0;

  ber_win_cnt #(.BW_BIT(16), .BW_ERR(16)) dut_a (
    .RSTX(rstx), .CLK(clk), .START(start), .ABORT(abort), .WIN(win), .VLD(vld), .ERR(err),
    .BUSY(busy_a), .DONE(done_a), .BIT_CNT(bit_a), .ERR_CNT(errc_a), .ERR_SAT(sat_a)
  );

  ber_win_cnt #(.BW_BIT(16), .BW_ERR(4)) dut_b (
    .RSTX(rstx), .CLK(clk), .START(start), .ABORT(abort), .WIN(win), .VLD(vld), .ERR(err),
    .BUSY(busy_b), .DONE(done_b), .BIT_CNT(bit_b), .ERR_CNT(errc_b), .ERR_SAT(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: track raw bit/error tallies, clamp only when a result is published
  int   m_run, m_win, m_bits, m_errs;
  logic m_done;
  int   m_res_a, m_res_b;
  logic m_sat_a, m_sat_b;

  task automatic model_reset();
    m_run = 0; m_win = 0; m_bits = 0; m_errs = 0; m_done = 1'b0;
    m_res_a = 0; m_res_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
  endtask

  task automatic model_finish(input int errs);
    m_run   = 0;
    m_done  = 1'b1;
    m_res_a = (errs > 65535) ? 65535 : errs;
    m_sat_a = (errs > 65535);
    m_res_b = (errs > 15) ? 15 : errs;
    m_sat_b = (errs > 15);
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (abort) begin
      m_run = 0;
    end else if (start) begin
      m_run = 1; m_win = int'(win); m_bits = 0; m_errs = 0;
    end else if (m_run == 1) begin
      if (m_win == 0) begin
        model_finish(0);
      end else if (vld) begin
        m_bits++;
        if (err) m_errs++;
        if (m_bits == m_win) model_finish(m_errs);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("busy_a", 32'(busy_a), 32'(m_run));
    check("done_a", 32'(done_a), 32'(m_done));
    check("bit_a",  32'(bit_a),  32'(m_bits));
    check("errc_a", 32'(errc_a), 32'(m_res_a));
    check("sat_a",  32'(sat_a),  32'(m_sat_a));
    check("busy_b", 32'(busy_b), 32'(m_run));
    check("done_b", 32'(done_b), 32'(m_done));
    check("bit_b",  32'(bit_b),  32'(m_bits));
    check("errc_b", 32'(errc_b), 32'(m_res_b));
    check("sat_b",  32'(sat_b),  32'(m_sat_b));
  endtask

  task automatic applyStimulus(input logic s, input logic a, input int w, input logic v, input logic e);
    start = s; abort = a; win = 16'(w); vld = v; err = e;
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  typedef struct {
    logic s, a;
    int   w;
    logic v, e;
    logic eb, ed;
    int   ebit, eerr;
    logic es;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic a, input int w, input logic v, input logic e,
                         input logic eb, input logic ed, input int ebit, input int eerr, input logic es);
    vec_t t;
    t.s = s; t.a = a; t.w = w; t.v = v; t.e = e;
    t.eb = eb; t.ed = ed; t.ebit = ebit; t.eerr = eerr; t.es = es;
    vecs.push_back(t);
  endtask

  initial begin
    rstx = 1'b0; start = 1'b0; abort = 1'b0; win = '0; vld = 1'b0; err = 1'b0;
    model_reset();
    #12;
    checkOutput();
    @(posedge clk);
    #1;
    rstx = 1'b1;

    // Window of 8, errors on bits 2 and 5
    add_vec(1,0,8,0,0, 1,0,0,0,0);
    for (int i = 1; i <= 8; i++)
      add_vec(0,0,0,1,(i == 2 || i == 5), (i < 8), (i == 8), i, (i == 8) ? 2 : 0, 0);
    add_vec(0,0,0,0,0, 0,0,8,2,0);
    // Window of 5, gapped VLD with ERR tied high; VLD in the START cycle is ignored
    add_vec(1,0,5,1,1, 1,0,0,2,0);
    add_vec(0,0,0,1,1, 1,0,1,2,0);
    add_vec(0,0,0,0,1, 1,0,1,2,0);
    add_vec(0,0,0,0,1, 1,0,1,2,0);
    add_vec(0,0,0,1,1, 1,0,2,2,0);
    add_vec(0,0,0,1,1, 1,0,3,2,0);
    add_vec(0,0,0,0,1, 1,0,3,2,0);
    add_vec(0,0,0,1,1, 1,0,4,2,0);
    add_vec(0,0,0,1,1, 0,1,5,5,0);
    add_vec(0,0,0,1,1, 0,0,5,5,0);
    // Abort after 4 bits, then START together with ABORT
    add_vec(1,0,10,0,0, 1,0,0,5,0);
    for (int i = 1; i <= 4; i++) add_vec(0,0,0,1,0, 1,0,i,5,0);
    add_vec(0,1,0,1,1, 0,0,4,5,0);
    add_vec(1,1,3,1,0, 0,0,4,5,0);
    add_vec(0,0,0,1,0, 0,0,4,5,0);
    // Zero-length window
    add_vec(1,0,0,0,0, 1,0,0,5,0);
    add_vec(0,0,0,0,0, 0,1,0,0,0);
    add_vec(0,0,0,0,0, 0,0,0,0,0);
    // Restart mid-window discards errored bits of the old window
    add_vec(1,0,6,0,0, 1,0,0,0,0);
    for (int i = 1; i <= 3; i++) add_vec(0,0,0,1,1, 1,0,i,0,0);
    add_vec(1,0,2,1,1, 1,0,0,0,0);
    add_vec(0,0,0,1,0, 1,0,1,0,0);
    add_vec(0,0,0,1,0, 0,1,2,0,0);
    // START coincident with the finishing VLD: restart wins
    add_vec(1,0,2,0,0, 1,0,0,0,0);
    add_vec(0,0,0,1,1, 1,0,1,0,0);
    add_vec(1,0,3,1,1, 1,0,0,0,0);
    add_vec(0,1,0,0,0, 0,0,0,0,0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].s, vecs[k].a, vecs[k].w, vecs[k].v, vecs[k].e);
      check($sformatf("vec%0d busy", k), 32'(busy_a), 32'(vecs[k].eb));
      check($sformatf("vec%0d done", k), 32'(done_a), 32'(vecs[k].ed));
      check($sformatf("vec%0d bit",  k), 32'(bit_a),  32'(vecs[k].ebit));
      check($sformatf("vec%0d errc", k), 32'(errc_a), 32'(vecs[k].eerr));
      check($sformatf("vec%0d sat",  k), 32'(sat_a),  32'(vecs[k].es));
    end

    // 4-bit error counter saturates over a fully errored 20-bit window
    applyStimulus(1,0,20,0,0);
    repeat (20) applyStimulus(0,0,0,1,1);
    check("satwin done_b", 32'(done_b), 32'd1);
    check("satwin errc_b", 32'(errc_b), 32'd15);
    check("satwin sat_b",  32'(sat_b),  32'd1);
    check("satwin errc_a", 32'(errc_a), 32'd20);
    check("satwin sat_a",  32'(sat_a),  32'd0);
    applyStimulus(1,0,3,0,0);
    repeat (3) applyStimulus(0,0,0,1,0);
    check("clean errc_b", 32'(errc_b), 32'd0);
    check("clean sat_b",  32'(sat_b),  32'd0);
    check("clean done_b", 32'(done_b), 32'd1);

    // Asynchronous reset in the middle of a window
    applyStimulus(1,0,10,0,0);
    repeat (3) applyStimulus(0,0,0,1,1);
    #2;
    rstx = 1'b0;
    #1;
    model_reset();
    check("arst busy_a", 32'(busy_a), 32'd0);
    check("arst bit_a",  32'(bit_a),  32'd0);
    check("arst errc_a", 32'(errc_a), 32'd0);
    check("arst done_a", 32'(done_a), 32'd0);
    check("arst busy_b", 32'(busy_b), 32'd0);
    check("arst bit_b",  32'(bit_b),  32'd0);
    @(posedge clk);
    #1;
    checkOutput();
    rstx = 1'b1;
    applyStimulus(0,0,0,1,1);

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 4, $urandom_range(199) < 2,
                    int'($urandom_range(40)), $urandom_range(99) < 70, $urandom_range(99) < 40);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ber_win_cnt.md
# ber_win_cnt

Measurement-window error counter for the BER tester. It counts compared bits upward from zero to a programmed window length, and it counts mismatched bits in a saturating up-counter. At window end it latches the error total and emits a one-cycle completion pulse. It sits after the pattern comparator and is the counting-up counterpart to the reload down-counters used for interval timing.

## Interface
- BW_BIT, 16: width of window length and bit counter
- BW_ERR, 16: width of error counter and result

- RSTX  in  1  asynchronous reset, active-low
- CLK  in  1  clock, rising edge
- START  in  1  begin (or restart) a measurement; sampled every cycle
- ABORT  in  1  cancel measurement without result
- WIN  in  BW_BIT  window length in compared bits; sampled only when START is accepted
- VLD  in  1  one compared bit is present this cycle
- ERR  in  1  the present bit mismatched; ignored when VLD=0
- BUSY  out  1  measurement in progress
- DONE  out  1  one-cycle pulse: window completed, result valid
- BIT_CNT  out  BW_BIT  live count of compared bits in current/last window
- ERR_CNT  out  BW_ERR  latched error total of last completed window
- ERR_SAT  out  1  latched: error counter saturated during last completed window

## Operation
- Two states: IDLE and RUN. BUSY=1 exactly in RUN.
- Internal registers: win_r (BW_BIT), live error counter err_r (BW_ERR), sat_r.
- Priority each cycle: ABORT > START > counting.
- ABORT (any state): next state IDLE. No DONE. ERR_CNT/ERR_SAT unchanged. BIT_CNT holds its current value.
- START without ABORT (IDLE or RUN): next state RUN; win_r<=WIN; BIT_CNT, err_r, sat_r <= 0. VLD in that cycle is not counted. If already in RUN, the old window is discarded with no DONE.
- RUN, no START/ABORT:
  - If win_r==0: go to IDLE and finish with a zero result.
  - Otherwise, on VLD=1: BIT_CNT+1. If ERR=1, err_r+1, saturating at all-ones. An increment attempted while err_r is already all-ones sets sat_r.
  - When a counted VLD makes BIT_CNT reach win_r, finish in the same edge.
- Finish: next state IDLE; ERR_CNT <= error total including the final bit; ERR_SAT <= sat including the final bit; DONE=1 for one cycle.
- IDLE: VLD/ERR ignored; BIT_CNT holds final value until next START.
- Counters never wrap. BIT_CNT stops at win_r ≤ 2^BW_BIT−1, and err_r saturates.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, BIT_CNT=0, ERR_CNT=0, ERR_SAT=0, win_r=0, err_r=0.
- Reset mid-measurement: immediate return to all reset values; no DONE.
- All outputs are registered.
- START accepted at cycle n → BUSY=1, BIT_CNT=0 at n+1. The first countable VLD is at n+1.
- Last counted VLD at cycle m → at m+1: BUSY=0, DONE=1, ERR_CNT/ERR_SAT updated, BIT_CNT=win_r. At m+2: DONE=0.
- WIN=0: START at n → BUSY=1 at n+1 → at n+2 BUSY=0, DONE=1, ERR_CNT=0, ERR_SAT=0.
- START in the same cycle as the finishing VLD: restart wins. No DONE, ERR_CNT unchanged.
- Minimum gap between windows: START may be asserted in the cycle DONE is high. BUSY is then 1 at the following edge.
- DONE never asserts while ABORT or reset caused the exit.

## Test plan
- Reset, START with WIN=8, 8 consecutive VLD with ERR on bits 2 and 5 → DONE pulse one cycle after 8th VLD, ERR_CNT=2, BIT_CNT=8, ERR_SAT=0, BUSY drops with DONE.
- WIN=5 with VLD gapped (1,0,0,1,1,0,1,1) and ERR tied 1 but VLD=0 on gaps → ERR_CNT=5; ERR during VLD=0 and during IDLE not counted; VLD in START cycle ignored.
- BW_ERR=4, WIN=20, all bits errored → ERR_CNT=15, ERR_SAT=1. Next window WIN=3, no errors → ERR_CNT=0, ERR_SAT=0.
- WIN=10, ABORT after 4 bits → BUSY=0 next cycle, no DONE, ERR_CNT keeps previous result, BIT_CNT=4. Then START with ABORT in the same cycle → stays IDLE.
- Restart: WIN=6, after 3 bits assert START with WIN=2 → counters cleared, DONE only after 2 further VLD; START coincident with the final VLD of a window → no DONE.
- WIN=0 → DONE exactly 2 cycles after START, ERR_CNT=0. Assert RSTX low mid-window → all outputs return to reset values asynchronously.
